// File: rtl/ua_booth_mult_if.sv
`default_nettype none
// ============================================================================
//  Module      : ua_booth_mult_if
//  Description : y-signal bundle between the Booth control automaton (master)
//                and the multiplication datapath (slave). The abort line is
//                present only when UA_ABORT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface ua_booth_mult_if;
   logic start;
   logic rb0;
   logic q1;
`ifdef UA_ABORT_EN
   logic abort;
`endif
   logic y1;
   logic y2;
   logic y3;
   logic y4;
   logic y5;
   logic y6;
   logic y7;
   logic p0;
   logic busy;
   logic done;

   modport master (
      input  start, rb0, q1,
`ifdef UA_ABORT_EN
      input  abort,
`endif
      output y1, y2, y3, y4, y5, y6, y7, p0, busy, done
   );

   modport slave (
      output start, rb0, q1,
`ifdef UA_ABORT_EN
      output abort,
`endif
      input  y1, y2, y3, y4, y5, y6, y7, p0, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/ua_booth_mult.sv
`default_nettype none
// ============================================================================
//  Module      : ua_booth_mult
//  Description : Moore control automaton for a signed radix-2 Booth
//                multiplier datapath. Sequences operand loads, +/-RA
//                selection, accumulator write-back and the arithmetic shift
//                for N iterations. Optional macro UA_ABORT_EN adds an abort
//                input that returns the FSM to IDLE from any busy state.
//  Revision    : 1.0  initial release
// ============================================================================
module ua_booth_mult #(
   parameter int N = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   ua_booth_mult_if.master    bus
);

   localparam int              CW    = $clog2(N + 1);
   localparam logic [CW-1:0]   C_N   = CW'(N);
   localparam logic [CW-1:0]   C_ONE = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_ADDP  = 3'd3,
      S_ADDM  = 3'd4,
      S_SHIFT = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic [CW-1:0]   w_cnt_dec;
   logic            w_abort;

`ifdef UA_ABORT_EN
   assign w_abort = bus.abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_cnt_dec = r_cnt - C_ONE;

   // State and iteration-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state and next-count decode; abort overrides any busy state.
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_next = S_LOAD;
         end
         S_LOAD: begin
            w_cnt_next = C_N;
            w_next     = S_CHECK;
         end
         S_CHECK: begin
            case ({bus.rb0, bus.q1})
               2'b10:   w_next = S_ADDM;
               2'b01:   w_next = S_ADDP;
               default: w_next = S_SHIFT;
            endcase
         end
         S_ADDP:  w_next = S_SHIFT;
         S_ADDM:  w_next = S_SHIFT;
         S_SHIFT: begin
            w_cnt_next = w_cnt_dec;
            w_next     = (w_cnt_dec == '0) ? S_DONE : S_CHECK;
         end
         S_DONE:  w_next = S_IDLE;
         default: begin
            w_next     = S_IDLE;
            w_cnt_next = '0;
         end
      endcase
      if (w_abort && (r_state != S_IDLE)) begin
         w_next     = S_IDLE;
         w_cnt_next = '0;
      end
   end

   // Moore outputs: pure decode of the state register.
   always_comb begin
      bus.y1   = 1'b0;
      bus.y2   = 1'b0;
      bus.y3   = 1'b0;
      bus.y4   = 1'b0;
      bus.y5   = 1'b0;
      bus.y6   = 1'b0;
      bus.y7   = 1'b0;
      bus.p0   = 1'b0;
      bus.done = 1'b0;
      bus.busy = (r_state != S_IDLE);
      case (r_state)
         S_LOAD: begin
            bus.y1 = 1'b1;
            bus.y2 = 1'b1;
            bus.y3 = 1'b1;
         end
         S_ADDP: begin
            bus.y4 = 1'b1;
            bus.y6 = 1'b1;
         end
         // p0 supplies the +1 that turns ~RA into -RA.
         S_ADDM: begin
            bus.y5 = 1'b1;
            bus.y6 = 1'b1;
            bus.p0 = 1'b1;
         end
         S_SHIFT: bus.y7   = 1'b1;
         S_DONE:  bus.done = 1'b1;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ua_booth_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ua_booth_mult
//  Description : Self-checking bench for ua_booth_mult (N=4). A small
//                datapath model answers the y-signals; results are compared
//                against Booth recoding and signed products computed
//                directly from the operands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ua_booth_mult;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   ua_booth_mult_if ifc ();

   ua_booth_mult #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   // Datapath model: RA, RB, Q[-1] and a 2N-bit accumulator RS.
   logic [3:0] a_bus;
   logic [3:0] b_bus;
   logic [3:0] m_ra;
   logic [3:0] m_rb;
   logic       m_q;
   logic [7:0] m_rs;
   logic [7:0] w_ra_x;
   logic [9:0] outv;

   assign w_ra_x  = {{4{m_ra[3]}}, m_ra};
   assign ifc.rb0 = m_rb[0];
   assign ifc.q1  = m_q;
   assign outv    = {ifc.y1, ifc.y2, ifc.y3, ifc.y4, ifc.y5, ifc.y6, ifc.y7,
                     ifc.p0, ifc.busy, ifc.done};

   always @(posedge clk) begin
      if (ifc.y1) m_ra <= a_bus;
      if (ifc.y2) begin
         m_rb <= b_bus;
         m_q  <= 1'b0;
      end
      if (ifc.y3) m_rs <= 8'h00;
      if (ifc.y6)
         m_rs <= m_rs + (ifc.y4 ? w_ra_x : (ifc.y5 ? ~w_ra_x : 8'h00))
                      + {7'b0, ifc.p0};
      if (ifc.y7) {m_rs, m_rb, m_q} <= {m_rs[7], m_rs, m_rb};
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Booth recoding of b: code 2 = subtract RA, 1 = add RA, per iteration.
   function automatic void booth_ref(input logic [3:0] b,
                                     output logic [31:0] seq, output int na);
      logic prev;
      prev = 1'b0;
      seq  = '0;
      na   = 0;
      for (int i = 0; i < N; i++) begin
         if (b[i] && !prev) begin seq = (seq << 2) | 32'd2; na++; end
         if (!b[i] && prev) begin seq = (seq << 2) | 32'd1; na++; end
         prev = b[i];
      end
   endfunction

   function automatic logic [7:0] prod_ref(input logic [3:0] a,
                                           input logic [3:0] b);
      int sa;
      int sb;
      sa = a[3] ? int'(a) - 16 : int'(a);
      sb = b[3] ? int'(b) - 16 : int'(b);
      return 8'((sa * sb) & 32'hFF);
   endfunction

   // One multiplication; entered #1 after an edge with the FSM in IDLE.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                         input bit hold);
      int          lat;
      int          nadd;
      int          ny7;
      int          nload;
      int          exp_na;
      logic [31:0] seq;
      logic [31:0] exp_seq;
      bit          ok_busy;
      bit          ok_excl;
      bit          got_done;
      lat = 0; nadd = 0; ny7 = 0; nload = 0; seq = '0;
      ok_busy = 1'b1; ok_excl = 1'b1; got_done = 1'b0;
      booth_ref(b, exp_seq, exp_na);
      a_bus = a;
      b_bus = b;
      ifc.start = 1'b1;
      @(posedge clk); #1;
      chk("load", {28'b0, ifc.y1, ifc.y2, ifc.y3, ifc.busy}, 32'hF);
      if (!hold) ifc.start = 1'b0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (ifc.done) begin
            got_done = 1'b1;
            break;
         end
         if (!ifc.busy) ok_busy = 1'b0;
         if ((ifc.y4 && ifc.y5) || (ifc.p0 != ifc.y5)) ok_excl = 1'b0;
         if (ifc.y4) begin seq = (seq << 2) | 32'd1; nadd++; end
         if (ifc.y5) begin seq = (seq << 2) | 32'd2; nadd++; end
         if (ifc.y7) ny7++;
         if (ifc.y1) nload++;
      end
      chk("done_seen", {31'b0, got_done}, 32'd1);
      chk("latency", lat, 1 + 2 * N + exp_na);
      chk("add_seq", seq, exp_seq);
      chk("add_cnt", nadd, exp_na);
      chk("shift_cnt", ny7, N);
      chk("busy_held", {31'b0, ok_busy && ifc.busy}, 32'd1);
      chk("y4y5_p0", {31'b0, ok_excl}, 32'd1);
      chk("extra_load", nload, 0);
      chk("done_outs", {24'b0, outv[9:2]}, 32'd0);
      chk("product", {24'b0, m_rs[3:0], m_rb}, {24'b0, prod_ref(a, b)});
      if (!hold) begin
         @(posedge clk); #1;
         chk("idle_after", {22'b0, outv}, 32'd0);
      end
   endtask

   initial begin
      ifc.start = 1'b0;
`ifdef UA_ABORT_EN
      ifc.abort = 1'b0;
`endif
      a_bus = '0;
      b_bus = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {22'b0, outv}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed operands from the plan.
      run_op(4'd3, 4'b0000, 1'b0);
      run_op(4'd3, 4'b1110, 1'b0);
      run_op(4'd3, 4'b0101, 1'b0);
      run_op(4'b1000, 4'b1000, 1'b0);

      // Reset while in ADDM (RB=0001 subtracts in iteration 1).
      a_bus = 4'd5;
      b_bus = 4'b0001;
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("in_addm", {29'b0, ifc.y5, ifc.p0, ifc.y6}, 32'd7);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_outs", {22'b0, outv}, 32'd0);
      begin
         bit quiet;
         quiet = 1'b1;
         repeat (4) begin
            @(posedge clk); #1;
            if (outv != '0) quiet = 1'b0;
         end
         chk("rst_no_done", {31'b0, quiet}, 32'd1);
      end
      run_op(4'd5, 4'b0001, 1'b0);

      // Random operands.
      for (int i = 0; i < 10; i++)
         run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);

      // Start held high: DONE returns to IDLE, then exactly one new LOAD.
      run_op(4'd7, 4'b1011, 1'b1);
      @(posedge clk); #1;
      chk("hold_idle", {22'b0, outv}, 32'd0);
      @(posedge clk); #1;
      chk("hold_reload", {29'b0, ifc.y1, ifc.busy, ifc.done}, 32'd6);
      ifc.start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("hold_rst", {22'b0, outv}, 32'd0);

`ifdef UA_ABORT_EN
      // Abort during the SHIFT of iteration 2.
      a_bus = 4'd3;
      b_bus = 4'b0000;
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("abort_in_shift", {31'b0, ifc.y7}, 32'd1);
      ifc.abort = 1'b1;
      @(posedge clk); #1;
      ifc.abort = 1'b0;
      chk("abort_outs", {22'b0, outv}, 32'd0);
      chk("abort_cnt", {29'b0, dut.r_cnt}, 32'd0);
      begin
         bit quiet;
         quiet = 1'b1;
         repeat (12) begin
            @(posedge clk); #1;
            if (outv != '0) quiet = 1'b0;
         end
         chk("abort_no_done", {31'b0, quiet}, 32'd1);
      end
      run_op(4'd6, 4'b1101, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
